// File: rtl/cpu_pkg.sv
// Shared CPU constants: default register-file geometry and the hardwired zero register.
package cpu_pkg;

    localparam int DW_DEF   = 32;
    localparam int NREG_DEF = 32;
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/grf_scoreboard.sv
// Per-register pending bits: retiring writes clear, issue sets, and set beats clear.
module grf_scoreboard
    import cpu_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int AW     = $clog2(NREG),
    parameter int NUM_WR = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    output logic [NREG-1:0]      pend_vec
);

    logic [NREG-1:0] r_pend;
    logic [NREG-1:0] w_pend_next;

    always_comb begin
        w_pend_next = r_pend;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(REG_ZERO))) begin
                w_pend_next[wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        // The issuing instruction is a newer producer than whatever retires now.
        if (iss_en && (iss_addr != AW'(REG_ZERO))) begin
            w_pend_next[iss_addr] = 1'b1;
        end
        w_pend_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    assign pend_vec = r_pend;

endmodule

// File: rtl/grf_mp_bypass.sv
// Multi-port GRF with write-to-read bypass, pending scoreboard and optional write trace.
module grf_mp_bypass
    import cpu_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int AW     = $clog2(NREG),
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int TRACE  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    output logic [NUM_RD*DW-1:0] rd_data,
    output logic [NUM_RD-1:0]    rd_pend,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic [NUM_WR*DW-1:0] wr_data,
    input  logic [NUM_WR*32-1:0] wr_pc,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    output logic [NREG-1:0]      pend_vec
);

    logic [DW-1:0]     r_regs [NREG];
    logic [AW-1:0]     w_wa   [NUM_WR];
    logic [DW-1:0]     w_wd   [NUM_WR];
    logic [NUM_WR-1:0] w_wvld;
    logic [NUM_WR-1:0] w_shadowed;

    for (genvar j = 0; j < NUM_WR; j++) begin : g_wr_unpack
        assign w_wa[j]   = wr_addr[j*AW +: AW];
        assign w_wd[j]   = wr_data[j*DW +: DW];
        assign w_wvld[j] = wr_en[j] && (wr_addr[j*AW +: AW] != AW'(REG_ZERO));
    end

    // A port is shadowed when a higher-index port writes the same register.
    always_comb begin
        w_shadowed = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            for (int k = j + 1; k < NUM_WR; k++) begin
                if (w_wvld[k] && (w_wa[k] == w_wa[j])) begin
                    w_shadowed[j] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (w_wvld[j]) begin
                    r_regs[w_wa[j]] <= w_wd[j];
                end
            end
        end
    end

    grf_scoreboard #(
        .NREG   (NREG),
        .AW     (AW),
        .NUM_WR (NUM_WR)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .pend_vec (pend_vec)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_hit;
        logic [DW-1:0] w_byp;

        assign w_ra = rd_addr[i*AW +: AW];

        // Ascending scan so the highest-index matching port is the one left in w_byp.
        always_comb begin
            w_hit = 1'b0;
            w_byp = '0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (w_wvld[j] && (w_wa[j] == w_ra)) begin
                    w_hit = 1'b1;
                    w_byp = w_wd[j];
                end
            end
        end

        assign rd_data[i*DW +: DW] = (w_ra == AW'(REG_ZERO)) ? '0 :
                                     w_hit                   ? w_byp : r_regs[w_ra];
        assign rd_pend[i] = (w_ra != AW'(REG_ZERO)) && pend_vec[w_ra] && !w_hit;
    end

`ifndef SYNTHESIS
    if (TRACE != 0) begin : g_trace
        always_ff @(posedge clk) begin
            if (!reset) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (w_wvld[j] && !w_shadowed[j]) begin
                        $display("@%h: $%d <= %h", wr_pc[j*32 +: 32], w_wa[j], w_wd[j]);
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_grf_mp_bypass.sv
// Bench for grf_mp_bypass: directed scenarios plus random traffic against a reference model.
module tb_grf_mp_bypass;

    localparam int DW     = 32;
    localparam int NREG   = 32;
    localparam int AW     = 5;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_RD*AW-1:0] rd_addr;
    logic [NUM_RD*DW-1:0] rd_data;
    logic [NUM_RD-1:0]    rd_pend;
    logic [NUM_WR-1:0]    wr_en;
    logic [NUM_WR*AW-1:0] wr_addr;
    logic [NUM_WR*DW-1:0] wr_data;
    logic [NUM_WR*32-1:0] wr_pc;
    logic                 iss_en;
    logic [AW-1:0]        iss_addr;
    logic [NREG-1:0]      pend_vec;

    logic [DW-1:0]   m_regs [NREG];
    logic [NREG-1:0] m_pend;
    logic [31:0]     exp_q [$];
    string           tag_q [$];
    int              n_checks = 0;
    int              n_errors = 0;

    grf_mp_bypass #(
        .DW     (DW),
        .NREG   (NREG),
        .NUM_RD (NUM_RD),
        .NUM_WR (NUM_WR),
        .TRACE  (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_pend  (rd_pend),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_pc    (wr_pc),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .pend_vec (pend_vec)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic idle_inputs();
        reset    = 1'b0;
        rd_addr  = '0;
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        wr_pc    = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en[p]             = 1'b1;
        wr_addr[p*AW +: AW]  = a;
        wr_data[p*DW +: DW]  = d;
        wr_pc[p*32 +: 32]    = 32'h0000_1000 + 32'(p * 4);
    endtask

    // Inputs are held from one negedge to the next; expectations come from the model before the edge.
    task automatic step(input bit chk);
        logic [AW-1:0] ra;
        logic          hit;
        logic [DW-1:0] byp;
        logic [31:0]   got;
        if (chk) begin
            for (int i = 0; i < NUM_RD; i++) begin
                ra  = rd_addr[i*AW +: AW];
                hit = 1'b0;
                byp = '0;
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] && wr_addr[j*AW +: AW] != 0 && wr_addr[j*AW +: AW] == ra) begin
                        hit = 1'b1;
                        byp = wr_data[j*DW +: DW];
                    end
                end
                push_exp($sformatf("rd_data%0d@r%0d", i, ra), (ra == 0) ? 32'h0 : (hit ? byp : m_regs[ra]));
                push_exp($sformatf("rd_pend%0d@r%0d", i, ra), {31'b0, (ra != 0) && m_pend[ra] && !hit});
            end
            push_exp("pend_vec", m_pend);
            #1;
            for (int i = 0; i < NUM_RD; i++) begin
                got = rd_data[i*DW +: DW];
                check_val(tag_q.pop_front(), got, exp_q.pop_front());
                got = {31'b0, rd_pend[i]};
                check_val(tag_q.pop_front(), got, exp_q.pop_front());
            end
            check_val(tag_q.pop_front(), pend_vec, exp_q.pop_front());
        end
        @(posedge clk);
        if (reset) begin
            for (int r = 0; r < NREG; r++) m_regs[r] = '0;
            m_pend = '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] != 0) begin
                    m_regs[wr_addr[j*AW +: AW]] = wr_data[j*DW +: DW];
                    m_pend[wr_addr[j*AW +: AW]] = 1'b0;
                end
            end
            if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
        end
        @(negedge clk);
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) m_regs[r] = '0;
        m_pend = '0;
        idle_inputs();
        reset = 1'b1;
        step(1'b0);

        // Reset state
        idle_inputs(); set_rd(0, 5); set_rd(1, 31); step(1'b1);

        // Write with same-cycle bypass, then array read, then discarded write to r0
        idle_inputs(); set_wr(0, 3, 32'hDEADBEEF); set_rd(0, 3); step(1'b1);
        idle_inputs(); set_rd(0, 3); set_rd(1, 3); step(1'b1);
        idle_inputs(); set_wr(0, 0, 32'h1234); set_rd(0, 0); set_rd(1, 3); step(1'b1);
        idle_inputs(); set_rd(0, 0); step(1'b1);

        // Collision: port1 wins
        idle_inputs(); set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22); set_rd(0, 7); step(1'b1);
        idle_inputs(); set_rd(0, 7); set_rd(1, 3); step(1'b1);

        // Issue, then a retiring write resolves the hazard in the same cycle
        idle_inputs(); iss_en = 1'b1; iss_addr = 9; set_rd(0, 9); step(1'b1);
        idle_inputs(); set_rd(0, 9); step(1'b1);
        idle_inputs(); set_wr(1, 9, 32'hCAFE0009); set_rd(0, 9); set_rd(1, 9); step(1'b1);
        idle_inputs(); set_rd(0, 9); step(1'b1);

        // Set/clear race on r4, then issue to r0
        idle_inputs(); iss_en = 1'b1; iss_addr = 4; step(1'b1);
        idle_inputs(); iss_en = 1'b1; iss_addr = 4; set_wr(0, 4, 32'h44); set_rd(0, 4); step(1'b1);
        idle_inputs(); set_rd(0, 4); iss_en = 1'b1; iss_addr = 0; step(1'b1);
        idle_inputs(); set_rd(0, 4); step(1'b1);

        // Mid-operation reset discards data and pending state
        idle_inputs(); iss_en = 1'b1; iss_addr = 2; set_wr(0, 6, 32'h66); step(1'b1);
        idle_inputs(); iss_en = 1'b1; iss_addr = 6; set_wr(1, 2, 32'h22); step(1'b1);
        idle_inputs(); iss_en = 1'b1; iss_addr = 2; set_rd(0, 2); set_rd(1, 6); step(1'b1);
        idle_inputs(); reset = 1'b1; set_wr(0, 2, 32'hBAD); step(1'b0);
        idle_inputs(); set_rd(0, 2); set_rd(1, 6); step(1'b1);
        idle_inputs(); set_rd(0, 7); set_rd(1, 3); step(1'b1);

        // Random traffic over a narrow address window to provoke bypass and collisions
        for (int n = 0; n < 300; n++) begin
            idle_inputs();
            reset = ($urandom_range(0, 49) == 0);
            for (int i = 0; i < NUM_RD; i++) set_rd(i, AW'($urandom_range(0, 7)));
            for (int j = 0; j < NUM_WR; j++) begin
                if ($urandom_range(0, 1) == 1) set_wr(j, AW'($urandom_range(0, 7)), $urandom);
            end
            iss_en   = ($urandom_range(0, 2) == 0);
            iss_addr = AW'($urandom_range(0, 7));
            step(1'b1);
        end

        check_val("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/grf_mp_bypass.md
Name: grf_mp_bypass

Overview:
- Parametrised general-purpose register file for the pipelined CPU, successor to the single-port single-cycle GRF.
- Provides NUM_RD combinational read ports and NUM_WR synchronous write ports, with write-to-read bypass so the pipeline's WB stage needs no external forwarding mux.
- Adds a per-register pending scoreboard: ID sets a register's pending bit on issue, and the write port that retires it clears the bit. The hazard unit uses these bits for stall decisions.

Parameters:
- DW, 32, data width in bits.
- NREG, 32, number of architectural registers; must be a power of 2, ≥ 2.
- AW, $clog2(NREG), register address width; derived, not overridden.
- NUM_RD, 2, number of read ports.
- NUM_WR, 2, number of write ports; a higher index has higher priority.
- TRACE, 1, when 1 each committed write prints "@%h: $%d <= %h" (pc, addr, data).

Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: synchronous, active-high.
- rd_addr, in, NUM_RD*AW: read addresses; port i occupies slice [i*AW +: AW].
- rd_data, out, NUM_RD*DW: read data, combinational.
- rd_pend, out, NUM_RD: pending bit of each read address, after bypass.
- wr_en, in, NUM_WR: write enables.
- wr_addr, in, NUM_WR*AW: write addresses.
- wr_data, in, NUM_WR*DW: write data.
- wr_pc, in, NUM_WR*32: PC per write, used only for trace.
- iss_en, in, 1: mark a destination register pending.
- iss_addr, in, AW: destination register being issued.
- pend_vec, out, NREG: full scoreboard; bit 0 is always 0.

Behaviour:
- Storage: NREG x DW flops plus NREG pending bits. Register 0 is hardwired to 0 and never pending.
- Reset: on a posedge clk with reset=1, every register is cleared to 0 and every pending bit to 0. All writes and issues in that cycle are ignored. Afterwards rd_data reads 0 and rd_pend and pend_vec read 0. Reset asserted mid-operation behaves identically and discards in-flight pending state.
- Write: on a posedge with reset=0, for each j where wr_en[j]=1 and wr_addr[j]!=0, the register at wr_addr[j] takes wr_data[j].
  - Writes to register 0 are discarded, with no trace print and no effect on pending bits.
- Write collision: if several ports write the same address in one cycle, the highest-index port wins. Only the winner is traced.
- Read, combinational, same cycle:
  - rd_addr==0 → 0.
  - Else, if any enabled write port targets rd_addr (addr!=0) → the highest-index such wr_data (bypass).
  - Else → stored value.
- Scoreboard update at posedge, reset=0:
  - Clear pend[a] for every address a written by an enabled port (a!=0).
  - Then set pend[iss_addr] if iss_en=1 and iss_addr!=0.
  - Set has priority over clear on the same address in the same cycle, because the newer producer is in flight.
- rd_pend[i] is combinational:
  - rd_addr==0 → 0.
  - Else → pend[rd_addr] AND NOT (any enabled write to rd_addr this cycle).
  - A same-cycle write therefore resolves the hazard. iss_en in the same cycle does not affect rd_pend until the next cycle.
- Latency: write-to-array takes 1 cycle, but bypass makes the data visible with 0 cycles. Issue becomes visible in pend_vec after 1 cycle.
- Trace: when TRACE=1, one $display per committed winning write, in ascending port order. Trace is simulation-only and synthesis ignores it.
- Width rules: no arithmetic. Address widths are exact with no wrap, since all AW codes are valid registers.

Decomposition:
- Shared package cpu_pkg holds: DW and NREG defaults, and the REG_ZERO constant (0).
- Natural sub-module: grf_scoreboard. It holds the NREG pending bits with clear/set priority logic and exposes pend_vec.
- The data array, bypass mux and trace logic stay in grf_mp_bypass.

Test Plan:
- Reset then read: assert reset 1 cycle; read addrs 5 and 31 → rd_data=0, rd_pend=0, pend_vec=0.
- Write then read: write port0 reg 3 ← 0xDEADBEEF.
  - Same cycle, reading reg 3 → 0xDEADBEEF via bypass.
  - Next cycle, with no write → 0xDEADBEEF from the array.
  - Write reg 0 ← 0x1234 → reads 0 and prints no trace.
- Collision: port0 writes reg 7 ← 0x11 and port1 writes reg 7 ← 0x22 in the same cycle.
  - Same-cycle read → 0x22; the next-cycle read → 0x22.
  - Exactly one trace line is printed, for 0x22.
- Scoreboard: iss_en reg 9 → next cycle pend_vec[9]=1 and rd_pend=1 for reg 9.
  - Then writing reg 9 gives rd_pend=0 in the same cycle and pend_vec[9]=0 the next cycle.
- Set/clear race: with reg 4 pending, issue reg 4 and write reg 4 in the same cycle → pend_vec[4] stays 1. An issue to reg 0 → pend_vec[0] stays 0.
- Mid-op reset: pend regs 2, 6 and data regs nonzero; assert reset together with a write to reg 2 → next cycle all data reads 0 and pend_vec=0.
